i2c_slave_responder: RTL
========================

Name: i2c_slave_responder

Overview:
Synthesizable, parametrised I2C slave engine. It is the clocked successor to the bus-functional slave in the I2C interface package. It oversamples the open-drain SCL/SDA lines on the system clock and detects START, repeated START and STOP. It matches a programmable slave address, ACKs or NACKs it, and then either streams any number of written bytes out on a valid strobe or fetches read bytes through a request/avail handshake. It sits between the I2C bus wires and the test/system fabric and also serves as the reference responder for the I2C bench.

Parameters:
I2C_ADDR_WIDTH, 7, slave address bits (excludes R/W bit)
I2C_DATA_WIDTH, 8, bits per data byte
SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (minimum 2)
RD_IDLE_BYTE, 8'hFF, byte sent when a read byte is needed and rd_avail=0

Ports:
clk_i  in  1  system clock; must be at least 8x SCL frequency
rst_i  in  1  synchronous, active-high reset
scl_i  in  1  bus SCL, sampled
sda_i  in  1  bus SDA, sampled
sda_oe  out  1  1 = pull SDA low; 0 = release (open drain)
slave_addr  in  I2C_ADDR_WIDTH  address to match; sampled at the address-ACK decision
wr_full  in  1  1 = sink cannot accept a byte; the write byte is NACKed
wr_data  out  I2C_DATA_WIDTH  last received write byte
wr_valid  out  1  one-cycle pulse, wr_data valid
rd_req  out  1  one-cycle pulse requesting the next read byte
rd_avail  in  1  sampled together with rd_data in the rd_req cycle
rd_data  in  I2C_DATA_WIDTH  read byte, sampled in the rd_req cycle
start_det  out  1  pulse on START or repeated START
stop_det  out  1  pulse on STOP
busy  out  1  high from an address match until STOP
op_rd  out  1  R/W bit of the current addressed transfer (1 = read)
byte_cnt  out  16  data bytes in the current transfer; saturates at 16'hFFFF

Behaviour:
- Reset (rst_i synchronous): state=IDLE; sda_oe=0, wr_valid=0, rd_req=0, start_det=0, stop_det=0, busy=0, op_rd=0, byte_cnt=0, wr_data=0. Synchroniser flops reset to 1 (bus idle).
- Edge and condition detection: all edges come from synchronised signals one cycle apart.
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - Bit sample: scl rising edge.
  - Drive change: scl falling edge.
- START or STOP is honoured in every state and overrides the FSM.
  - START -> ADDR, clears the shift register and byte_cnt, sets start_det.
  - STOP -> IDLE, releases sda_oe, clears busy, sets stop_det.
- Reset asserted mid-transfer releases SDA immediately; the slave then ignores the bus until the next START.
- Bit order is MSB first for address and data.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - IDLE: wait for START.
  - ADDR: shift I2C_ADDR_WIDTH+1 bits; the last bit is R/W.
    - Match = (address bits == slave_addr).
    - Mismatch -> IGNORE (no ACK, no busy).
    - Match: at the next scl fall, drive sda_oe=1, set busy, latch op_rd -> ADDR_ACK.
  - ADDR_ACK: at the scl fall ending the ACK clock:
    - op_rd=0: release SDA -> WR_BYTE.
    - op_rd=1: pulse rd_req, load rd_data (or RD_IDLE_BYTE if rd_avail=0), drive its MSB -> RD_BYTE.
  - WR_BYTE: shift I2C_DATA_WIDTH bits. After the last sample, at scl fall:
    - wr_full=0: wr_data/wr_valid pulse, byte_cnt+1, sda_oe=1 (ACK).
    - wr_full=1: no pulse, no increment, SDA released (NACK).
    - Either case -> WR_ACK.
  - WR_ACK: at the scl fall ending the ACK clock, release SDA.
    - After ACK -> WR_BYTE.
    - After NACK -> IGNORE.
  - RD_BYTE: sda_oe = ~current bit, updated on each scl fall. After the last bit's scl fall, release SDA -> RD_ACK.
  - RD_ACK: sample master ACK on scl rise; byte_cnt+1.
    - ACK (sda=0): at scl fall pulse rd_req, load the next byte -> RD_BYTE.
    - NACK: -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- rd_req latency: the pulse occurs in the same cycle as the scl-fall detection. rd_data and rd_avail are sampled in that cycle, so the source must present data combinationally.
- START and STOP in the same synchronised sample cannot occur. If a START is detected during the last bit, START still wins.

Decomposition:
- Package i2c_responder_pkg:
  - typedef enum for the FSM states.
  - typedef i2c_op_t {I2C_WRITE=0, I2C_READ=1}.
  - Constants for the default idle byte and the sync depth.
- Sub-module i2c_line_sync: SYNC_STAGES synchroniser plus edge/START/STOP pulse generation for scl/sda, instantiated once.

Test Plan:
1. Write: slave_addr=7'h22; master START, 0x44 (addr 0x22, W), data 0xA5, 0x3C, STOP -> ACK on all three bytes; wr_valid twice with 0xA5 then 0x3C; byte_cnt=2; stop_det pulse; busy low after.
2. Read: master START, 0x45 (addr 0x22, R); rd_data 0x96 then 0x0F; master ACKs the first byte and NACKs the second -> SDA shows 0x96, 0x0F; rd_req pulses exactly twice; state IGNORE until STOP.
3. Mismatch: master addresses 0x50 -> SDA never driven low; no busy, wr_valid or rd_req; start_det pulse only.
4. Back-pressure: write 0x11 with wr_full=1 on the second byte -> first byte ACKed, second NACKed; only 1 wr_valid; later bytes ignored.
5. Repeated START: write 0x01, then repeated START with a read of addr 0x22 and rd_avail=0 -> start_det twice; read byte = 0xFF; op_rd goes 0->1; byte_cnt restarts.
6. Reset mid-read, during bit 3 of an RD_BYTE driving 0 -> sda_oe=0 the cycle after rst_i; slave silent until the next START; the next full write transfer succeeds.

Source files
------------

// File: rtl/i2c_responder_pkg.sv
// Shared state/op types and default constants for the I2C slave responder.
package i2c_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_IGNORE
   } resp_state_t;

   typedef enum logic {
      I2C_WRITE = 1'b0,
      I2C_READ  = 1'b1
   } i2c_op_t;

   localparam logic [7:0] RD_IDLE_BYTE_DEF = 8'hFF;
   localparam int         SYNC_DEPTH_DEF   = 2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and derives SCL edge and START/STOP condition pulses.
module i2c_line_sync
   import i2c_responder_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_DEPTH_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s, sda_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_s      = scl_sync_q[SYNC_STAGES-1];
      sda_s      = sda_sync_q[SYNC_STAGES-1];
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   // Reset to the idle bus level so leaving reset never fabricates an edge on a quiet bus.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign sda_o      = sda_s;
   assign scl_rise_o = scl_s & ~scl_prev_q;
   assign scl_fall_o = ~scl_s & scl_prev_q;
   assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// Oversampled I2C slave: address match, write streaming, read fetch via rd_req/rd_avail.
//   state       | meaning
//   ST_IDLE     | bus not addressed, wait for START
//   ST_ADDR     | shift address + R/W bit
//   ST_ADDR_ACK | driving address ACK
//   ST_WR_BYTE  | shift a write byte in
//   ST_WR_ACK   | driving (or withholding) write ACK
//   ST_RD_BYTE  | driving read byte bits
//   ST_RD_ACK   | sample master ACK/NACK
//   ST_IGNORE   | not ours / finished, wait for START or STOP
module i2c_slave_responder
   import i2c_responder_pkg::*;
#(
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter int                        SYNC_STAGES    = SYNC_DEPTH_DEF,
   parameter logic [I2C_DATA_WIDTH-1:0] RD_IDLE_BYTE   = RD_IDLE_BYTE_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_oe,
   input  logic [I2C_ADDR_WIDTH-1:0] slave_addr,
   input  logic                      wr_full,
   output logic [I2C_DATA_WIDTH-1:0] wr_data,
   output logic                      wr_valid,
   output logic                      rd_req,
   input  logic                      rd_avail,
   input  logic [I2C_DATA_WIDTH-1:0] rd_data,
   output logic                      start_det,
   output logic                      stop_det,
   output logic                      busy,
   output logic                      op_rd,
   output logic [15:0]               byte_cnt
);

   localparam int SHIFT_W = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH + 1
                                                                   : I2C_DATA_WIDTH;
   localparam int CNT_W   = $clog2(SHIFT_W + 1);
   localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(I2C_ADDR_WIDTH + 1);
   localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(I2C_DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic sda_s, scl_rise, scl_fall, start_s, stop_s;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_s),
      .stop_o     (stop_s)
   );

   resp_state_t               state_q, state_d;
   logic [SHIFT_W-1:0]        shift_q, shift_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic                      sda_oe_q, sda_oe_d;
   logic                      busy_q, busy_d;
   i2c_op_t                   op_q, op_d;
   logic [15:0]               byte_cnt_q, byte_cnt_d;
   logic [I2C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                      wr_valid_q, wr_valid_d;
   logic                      ack_q, ack_d;
   logic                      mack_q, mack_d;
   logic                      start_det_q, start_det_d;
   logic                      stop_det_q, stop_det_d;
   logic                      rd_req_c;
   logic [I2C_DATA_WIDTH-1:0] rd_byte;

   assign rd_byte = rd_avail ? rd_data : RD_IDLE_BYTE;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      op_d        = op_q;
      byte_cnt_d  = byte_cnt_q;
      wr_data_d   = wr_data_q;
      wr_valid_d  = 1'b0;
      ack_d       = ack_q;
      mack_d      = mack_q;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      rd_req_c    = 1'b0;

      if (start_s) begin
         state_d     = ST_ADDR;
         shift_d     = '0;
         bit_cnt_d   = ADDR_BITS;
         byte_cnt_d  = '0;
         sda_oe_d    = 1'b0;
         start_det_d = 1'b1;
      end else if (stop_s) begin
         state_d    = ST_IDLE;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b0;
         stop_det_d = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_IGNORE: sda_oe_d = 1'b0;

            ST_ADDR: begin
               if (scl_rise && bit_cnt_q != '0) begin
                  shift_d   = {shift_q[SHIFT_W-2:0], sda_s};
                  bit_cnt_d = bit_cnt_q - CNT_ONE;
               end else if (scl_fall && bit_cnt_q == '0) begin
                  if (shift_q[I2C_ADDR_WIDTH:1] == slave_addr) begin
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     op_d     = i2c_op_t'(shift_q[0]);
                     state_d  = ST_ADDR_ACK;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = DATA_BITS;
                  if (op_q == I2C_READ) begin
                     rd_req_c = 1'b1;
                     shift_d  = SHIFT_W'(rd_byte);
                     sda_oe_d = ~rd_byte[I2C_DATA_WIDTH-1];
                     state_d  = ST_RD_BYTE;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WR_BYTE;
                  end
               end
            end

            ST_WR_BYTE: begin
               if (scl_rise && bit_cnt_q != '0) begin
                  shift_d   = {shift_q[SHIFT_W-2:0], sda_s};
                  bit_cnt_d = bit_cnt_q - CNT_ONE;
               end else if (scl_fall && bit_cnt_q == '0) begin
                  state_d = ST_WR_ACK;
                  ack_d   = ~wr_full;
                  if (!wr_full) begin
                     wr_data_d  = shift_q[I2C_DATA_WIDTH-1:0];
                     wr_valid_d = 1'b1;
                     byte_cnt_d = sat_inc16(byte_cnt_q);
                     sda_oe_d   = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = DATA_BITS;
                  state_d   = ack_q ? ST_WR_BYTE : ST_IGNORE;
               end
            end

            // bit_cnt counts bits still on the wire, including the one being driven now.
            ST_RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == CNT_ONE) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     shift_d   = shift_q << 1;
                     sda_oe_d  = ~shift_q[I2C_DATA_WIDTH-2];
                     bit_cnt_d = bit_cnt_q - CNT_ONE;
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise) begin
                  mack_d     = ~sda_s;
                  byte_cnt_d = sat_inc16(byte_cnt_q);
               end else if (scl_fall) begin
                  if (mack_q) begin
                     rd_req_c  = 1'b1;
                     shift_d   = SHIFT_W'(rd_byte);
                     sda_oe_d  = ~rd_byte[I2C_DATA_WIDTH-1];
                     bit_cnt_d = DATA_BITS;
                     state_d   = ST_RD_BYTE;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         op_q        <= I2C_WRITE;
         byte_cnt_q  <= '0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         ack_q       <= 1'b0;
         mack_q      <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         op_q        <= op_d;
         byte_cnt_q  <= byte_cnt_d;
         wr_data_q   <= wr_data_d;
         wr_valid_q  <= wr_valid_d;
         ack_q       <= ack_d;
         mack_q      <= mack_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
      end
   end

   // rd_req is combinational so the source can answer in the same cycle; mask it during reset.
   assign rd_req    = rd_req_c & ~rst_i;
   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign op_rd     = (op_q == I2C_READ);
   assign byte_cnt  = byte_cnt_q;
   assign wr_data   = wr_data_q;
   assign wr_valid  = wr_valid_q;
   assign start_det = start_det_q;
   assign stop_det  = stop_det_q;

endmodule
